dm_access_ctrl: RTL

//  Sequencer between the core load/store path and a word-wide, synchronous-read data memory.

---
 rtl/dm_access_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dm_access_ctrl.sv
// Load/store sequencer for a word-wide synchronous-read data memory: converts byte/half/word
// requests into byte-enabled word beats, splitting word-crossing accesses into two beats.
module dm_access_ctrl #(
    parameter int ADDR_W         = 6,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_ctrl,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [32:0] DEPTH = 33'd4 << ADDR_W;

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]  word_q, word_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               split_q, split_d;
    logic [31:0]        beat0_q, beat0_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic [7:0]         mask_s;
    logic [4:0]         shift_s;

    function automatic logic [2:0] size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Two-word lane mask: low nibble is beat0 enables, high nibble is beat1 enables.
    function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
        logic [7:0] m;
        m = (8'd1 << size_of(sz)) - 8'd1;
        return m << off;
    endfunction

    function automatic logic crosses(input logic [1:0] sz, input logic [1:0] off);
        return (({1'b0, off} + size_of(sz)) > 3'd4);
    endfunction

    function automatic logic req_bad(input logic we, input logic [2:0] ctrl, input logic [31:0] addr);
        logic [2:0]  n;
        logic [32:0] last;
        n    = size_of(ctrl[1:0]);
        last = {1'b0, addr} + {30'd0, n} - 33'd1;
        return (ctrl[1:0] == 2'b11) || (ctrl == 3'b110) || (we && ctrl[2]) || (last >= DEPTH) ||
               (!MISALIGN_SPLIT && ((addr[1:0] & (n[1:0] - 2'd1)) != 2'b00));
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] ctrl, input logic [1:0] off,
                                           input logic [31:0] b1, input logic [31:0] b0);
        logic [31:0] raw;
        raw = 32'({b1, b0} >> {off, 3'b000});
        case (ctrl[1:0])
            2'b00:   return ctrl[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   return ctrl[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign mask_s  = lane_mask(ctrl_q[1:0], off_q);
    assign shift_s = {off_q, 3'b000};

    // Memory beat decode from the current state and the latched request.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = word_q;
        mem_be    = 4'b0000;
        mem_wdata = (wdata_q << shift_s) | (wdata_q >> (6'd32 - {1'b0, shift_s}));
        req_ready = (state_q == IDLE);
        case (state_q)
            ACC0: begin
                mem_en = 1'b1;
                mem_we = we_q;
                mem_be = mask_s[3:0];
            end
            ACC1: begin
                mem_en   = 1'b1;
                mem_we   = we_q;
                mem_be   = mask_s[7:4];
                mem_addr = word_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // Next-state, request latching and response staging.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        ctrl_d      = ctrl_q;
        word_d      = word_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        split_d     = split_q;
        beat0_d     = beat0_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    ctrl_d  = req_ctrl;
                    word_d  = req_addr[ADDR_W+1:2];
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    split_d = crosses(req_ctrl[1:0], req_addr[1:0]);
                    if (req_bad(req_we, req_ctrl, req_addr)) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                        state_d     = RESP;
                    end else begin
                        state_d = ACC0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACC0: begin
                if (split_q) begin
                    state_d = ACC1;
                end else if (we_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'd0;
                    state_d     = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            ACC1: begin
                if (we_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'd0;
                    state_d     = RESP;
                end else begin
                    beat0_d = mem_rdata;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = split_q ? extend(ctrl_q, off_q, mem_rdata, beat0_q)
                                      : extend(ctrl_q, off_q, 32'd0, mem_rdata);
                state_d     = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            ctrl_q      <= 3'd0;
            word_q      <= '0;
            off_q       <= 2'd0;
            wdata_q     <= 32'd0;
            split_q     <= 1'b0;
            beat0_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            ctrl_q      <= ctrl_d;
            word_q      <= word_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            split_q     <= split_d;
            beat0_q     <= beat0_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
